// File: rtl/sa_load_ctrl.sv
// Transaction sequencer for the systolic array: loads A/B operand sipos from a
// byte stream, starts the array, waits for done (watchdog), drains result indices.
//
// state   | meaning
// --------+-------------------------------------------------
// clear   | one-cycle pulse clearing both sipo write pointers
// load_a  | accept depth_p bytes into the A sipo
// load_b  | accept depth_p bytes into the B sipo
// run     | one-cycle array start pulse
// wait    | wait for done_i, watchdog counts idle cycles
// drain   | present result indices over valid/ready
module sa_load_ctrl #(
   parameter int width_p        = 8,
   parameter int depth_p        = 16,
   parameter int result_words_p = 16,
   parameter int timeout_p      = 1024
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              valid_i,
   input  logic [width_p-1:0]                data_i,
   output logic                              ready_o,
   output logic                              sipo_clear_o,
   output logic                              a_valid_o,
   output logic                              b_valid_o,
   output logic [width_p-1:0]                sipo_data_o,
   output logic                              start_o,
   input  logic                              done_i,
   output logic                              res_valid_o,
   input  logic                              res_ready_i,
   output logic [$clog2(result_words_p)-1:0] res_idx_o,
   output logic                              busy_o,
   output logic                              err_o,
   output logic [2:0]                        state_o
);

   localparam int cnt_w_lp  = ($clog2(depth_p) > $clog2(result_words_p)) ?
                              $clog2(depth_p) : $clog2(result_words_p);
   localparam int idx_w_lp  = $clog2(result_words_p);
   localparam int wdog_w_lp = $clog2(timeout_p);

   localparam logic [cnt_w_lp-1:0]  depth_last_lp = cnt_w_lp'(depth_p - 1);
   localparam logic [cnt_w_lp-1:0]  res_last_lp   = cnt_w_lp'(result_words_p - 1);
   localparam logic [wdog_w_lp-1:0] wdog_last_lp  = wdog_w_lp'(timeout_p - 1);

   typedef enum logic [2:0] {
      st_clear  = 3'd0,
      st_load_a = 3'd1,
      st_load_b = 3'd2,
      st_run    = 3'd3,
      st_wait   = 3'd4,
      st_drain  = 3'd5
   } state_t;

   state_t                state_r, state_n;
   logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
   logic [wdog_w_lp-1:0]  wdog_r, wdog_n;
   logic                  err_r, err_n;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= st_clear;
         cnt_r   <= '0;
         wdog_r  <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         wdog_r  <= wdog_n;
         err_r   <= err_n;
      end
   end

   // Strobes are gated by reset_i so nothing leaks out while the state
   // register still holds a pre-reset value.
   always_comb begin
      state_n      = state_r;
      cnt_n        = cnt_r;
      wdog_n       = wdog_r;
      err_n        = err_r;
      ready_o      = 1'b0;
      a_valid_o    = 1'b0;
      b_valid_o    = 1'b0;
      start_o      = 1'b0;
      res_valid_o  = 1'b0;
      sipo_clear_o = 1'b0;
      case (state_r)
         st_clear: begin
            sipo_clear_o = 1'b1;
            cnt_n        = '0;
            state_n      = st_load_a;
         end
         st_load_a, st_load_b: begin
            ready_o   = ~reset_i;
            a_valid_o = valid_i & ~reset_i & (state_r == st_load_a);
            b_valid_o = valid_i & ~reset_i & (state_r == st_load_b);
            if (valid_i) begin
               cnt_n = cnt_r + 1'b1;
               if (cnt_r == depth_last_lp) begin
                  cnt_n   = '0;
                  state_n = (state_r == st_load_a) ? st_load_b : st_run;
               end
            end
         end
         st_run: begin
            start_o = ~reset_i;
            wdog_n  = '0;
            state_n = st_wait;
         end
         st_wait: begin
            if (done_i) begin
               cnt_n   = '0;
               state_n = st_drain;
            end else begin
               wdog_n = wdog_r + 1'b1;
               if (wdog_r == wdog_last_lp) begin
                  err_n   = 1'b1;
                  state_n = st_clear;
               end
            end
         end
         st_drain: begin
            res_valid_o = ~reset_i;
            if (res_ready_i) begin
               cnt_n = cnt_r + 1'b1;
               if (cnt_r == res_last_lp) state_n = st_clear;
            end
         end
         default: state_n = st_clear;
      endcase
   end

   assign sipo_data_o = data_i;
   assign res_idx_o   = cnt_r[idx_w_lp-1:0];
   assign busy_o      = ~((state_r == st_load_a) && (cnt_r == '0));
   assign err_o       = err_r;
   assign state_o     = state_r;

endmodule

// File: tb/tb_sa_load_ctrl.sv
// Self-checking bench for sa_load_ctrl: directed transactions plus randomized
// ones, checked cycle by cycle against a transaction-level reference model.
module tb_sa_load_ctrl;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int RW    = 16;
   localparam int TO    = 1024;
   localparam int IW    = 4;

   localparam int M_CLR   = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_WAIT  = 3;
   localparam int M_DRAIN = 4;

   logic          clk_i = 1'b0;
   logic          reset_i, valid_i, done_i, res_ready_i;
   logic [W-1:0]  data_i;
   logic          ready_o, sipo_clear_o, a_valid_o, b_valid_o, start_o;
   logic          res_valid_o, busy_o, err_o;
   logic [W-1:0]  sipo_data_o;
   logic [IW-1:0] res_idx_o;
   logic [2:0]    state_o;

   sa_load_ctrl #(.width_p(W), .depth_p(DEPTH), .result_words_p(RW), .timeout_p(TO)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .sipo_clear_o(sipo_clear_o), .a_valid_o(a_valid_o),
      .b_valid_o(b_valid_o), .sipo_data_o(sipo_data_o), .start_o(start_o),
      .done_i(done_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_idx_o(res_idx_o), .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: where we are in the transaction, counted in bytes/cycles/words.
   int m_stage, m_taken, m_waited, m_sent;
   bit m_err;
   int drain_cyc;

   // Expected operand contents and a sipo model fed by the DUT strobes.
   logic [W-1:0] exp_a [DEPTH];
   logic [W-1:0] exp_b [DEPTH];
   logic [W-1:0] a_mem [DEPTH];
   logic [W-1:0] b_mem [DEPTH];
   int pa = 0, pb = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      bit acc, rst, s_clr, s_a, s_b;
      int exp_state;
      logic [W-1:0] s_d;
      #1;
      rst = reset_i;
      acc = valid_i && !rst && m_stage == M_LOAD;
      case (m_stage)
         M_CLR:   exp_state = 0;
         M_LOAD:  exp_state = (m_taken < DEPTH) ? 1 : 2;
         M_RUN:   exp_state = 3;
         M_WAIT:  exp_state = 4;
         default: exp_state = 5;
      endcase
      chk("state",      state_o,      exp_state);
      chk("ready",      ready_o,      32'(!rst && m_stage == M_LOAD));
      chk("a_valid",    a_valid_o,    32'(acc && m_taken < DEPTH));
      chk("b_valid",    b_valid_o,    32'(acc && m_taken >= DEPTH));
      chk("start",      start_o,      32'(!rst && m_stage == M_RUN));
      chk("res_valid",  res_valid_o,  32'(!rst && m_stage == M_DRAIN));
      chk("sipo_clear", sipo_clear_o, 32'(m_stage == M_CLR));
      chk("busy",       busy_o,       32'(!(m_stage == M_LOAD && m_taken == 0)));
      chk("err",        err_o,        32'(m_err));
      chk("sipo_data",  sipo_data_o,  data_i);
      if (!rst && m_stage == M_DRAIN) chk("res_idx", res_idx_o, m_sent);
      if (!rst && m_stage == M_RUN) begin
         chk("a_count", pa, DEPTH);
         chk("b_count", pb, DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            chk("a_elem", a_mem[i], exp_a[i]);
            chk("b_elem", b_mem[i], exp_b[i]);
         end
      end
      if (acc) begin
         if (m_taken < DEPTH) exp_a[m_taken] = data_i;
         else                 exp_b[m_taken - DEPTH] = data_i;
      end
      s_clr = sipo_clear_o; s_a = a_valid_o; s_b = b_valid_o; s_d = sipo_data_o;
      @(posedge clk_i);
      if (s_clr) begin pa = 0; pb = 0; end
      if (s_a && pa < DEPTH) begin a_mem[pa] = s_d; pa++; end
      if (s_b && pb < DEPTH) begin b_mem[pb] = s_d; pb++; end
      if (rst) begin
         m_stage = M_CLR; m_taken = 0; m_waited = 0; m_sent = 0; m_err = 0;
      end else begin
         case (m_stage)
            M_CLR:  begin m_stage = M_LOAD; m_taken = 0; end
            M_LOAD: if (acc) begin
                       m_taken++;
                       if (m_taken == 2 * DEPTH) m_stage = M_RUN;
                    end
            M_RUN:  begin m_stage = M_WAIT; m_waited = 0; end
            M_WAIT: if (done_i) begin
                       m_stage = M_DRAIN; m_sent = 0;
                    end else begin
                       m_waited++;
                       if (m_waited == TO) begin m_err = 1; m_stage = M_CLR; end
                    end
            default: if (res_ready_i) begin
                        m_sent++;
                        if (m_sent == RW) m_stage = M_CLR;
                     end
         endcase
      end
      #1;
   endtask

   // One full transaction. vpct: chance of valid_i; done_at: WAIT cycle on which
   // done_i rises (-1 never); rdy_mode 3 = ready every third drain cycle, else random.
   task automatic run_txn(input int vpct, input int done_at, input int rdy_mode,
                          input bit seq_data, input string name);
      bit ran = 0;
      drain_cyc = 0;
      for (int n = 0; n < 3000; n++) begin
         reset_i     = 1'b0;
         valid_i     = ($urandom_range(99, 0) < vpct);
         data_i      = seq_data ? W'(m_taken) : W'($urandom);
         done_i      = (m_stage == M_WAIT) ? (m_waited == done_at) : 1'($urandom_range(1, 0));
         res_ready_i = (m_stage == M_DRAIN && rdy_mode == 3) ? (drain_cyc % 3 == 2)
                                                              : 1'($urandom_range(1, 0));
         if (m_stage == M_DRAIN) drain_cyc++;
         cyc();
         if (m_stage == M_RUN) ran = 1;
         if (ran && m_stage == M_LOAD) break;
      end
      chk(name, 32'(ran && m_stage == M_LOAD), 1);
   endtask

   initial begin
      reset_i = 1'b1; valid_i = 1'b0; done_i = 1'b0; res_ready_i = 1'b0; data_i = '0;
      @(posedge clk_i);
      #1;
      m_stage = M_CLR; m_taken = 0; m_waited = 0; m_sent = 0; m_err = 0;

      // reset held, release, one clear cycle, then idle in LOAD_A
      cyc();
      cyc();
      reset_i = 1'b0;
      cyc();
      cyc();

      // back-to-back sequential load, done after 5 WAIT cycles, drain every third cycle
      run_txn(100, 5, 3, 1'b1, "txn_b2b");
      // gapped load
      run_txn(50, 0, 3, 1'b1, "txn_gapped");
      // watchdog timeout, then a normal transaction with err still set
      run_txn(100, -1, 0, 1'b0, "txn_timeout");
      run_txn(80, 3, 0, 1'b0, "txn_after_timeout");

      // reset after 20 accepted bytes
      for (int n = 0; n < 100 && m_taken < 20; n++) begin
         valid_i = 1'b1; data_i = W'($urandom); done_i = 1'b0; res_ready_i = 1'b0;
         cyc();
      end
      reset_i = 1'b1; valid_i = 1'b1;
      cyc();
      run_txn(100, 2, 0, 1'b0, "txn_after_reset");

      // done on the very last watchdog cycle wins over the timeout
      run_txn(100, TO - 1, 0, 1'b0, "txn_late_done");

      for (int t = 0; t < 6; t++)
         run_txn(int'($urandom_range(100, 30)), int'($urandom_range(40, 0)), 0, 1'b0, "txn_rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
